// File: rtl/radix4_online_result_collector.sv
// Result collector for the radix-4 online multiplier: drops the online-delay digits, converts the
// signed-digit stream on the fly (Q/QM), presents the aligned product on a valid/ack handshake.
// Optional illegal-digit (-4) detection: define RADIX4_COLLECT_DIGIT_CHECK_EN.
module radix4_online_result_collector #(
    parameter int unsigned no_of_digits = 4,
    parameter int unsigned radix_bits   = 3,
    parameter int unsigned delta        = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [radix_bits-1:0]     z,
    input  logic                      start,
    input  logic                      full_result_sel,
    input  logic                      result_ack,
    output logic [4*no_of_digits+1:0] result,
    output logic                      result_valid,
    output logic                      busy,
    output logic                      overrun,
    output logic                      digit_err
);

    localparam int unsigned RW       = 4 * no_of_digits + 2;
    localparam int unsigned CntW     = $clog2(2 * no_of_digits + delta + 1);
    localparam int unsigned SkipLast = (delta > 1) ? delta - 2 : 0;

    localparam logic [CntW-1:0] LastShort = CntW'(no_of_digits - 1);
    localparam logic [CntW-1:0] LastFull  = CntW'(2 * no_of_digits - 1);

    // StAlign is the cycle between the last digit and result_valid, where the result is aligned.
    typedef enum logic [2:0] {StIdle, StSkip, StCollect, StAlign, StDone} state_e;

    // The start cycle itself counts as the first skipped cycle.
    localparam state_e FirstState = (delta > 1) ? StSkip : StCollect;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            full_q, full_d;
    logic [RW-1:0]   q_q, q_d;
    logic [RW-1:0]   qm_q, qm_d;
    logic [RW-1:0]   result_q, result_d;
    logic            overrun_q, overrun_d;

    logic            accept;
    logic            illegal;
    logic [CntW-1:0] last_idx;
    logic [RW-1:0]   d_ext, q4, qm4, q_new, qm_new;
    logic            d_neg;

    assign accept   = start && ((state_q == StIdle) || ((state_q == StDone) && result_ack));
    assign last_idx = full_q ? LastFull : LastShort;

    // ------------------------------------------------------------------ FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------ FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = FirstState;
            end
            StSkip: begin
                if (cnt_q == CntW'(SkipLast)) state_d = StCollect;
            end
            StCollect: begin
                if (cnt_q == last_idx) state_d = StAlign;
            end
            StAlign: begin
                state_d = StDone;
            end
            StDone: begin
                if (result_ack) state_d = start ? FirstState : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------ FSM outputs
    always_comb begin
        busy         = (state_q == StSkip) || (state_q == StCollect);
        result_valid = (state_q == StDone);
    end

    // ------------------------------------------------------------------ on-the-fly conversion
    // Q holds the exact prefix value, QM = Q - 1; a negative digit borrows from QM instead of Q.
    always_comb begin
        d_ext = illegal ? '0 : {{(RW - radix_bits){z[radix_bits-1]}}, z};
        d_neg = d_ext[RW-1];
        q4    = {q_q[RW-3:0], 2'b00};
        qm4   = {qm_q[RW-3:0], 2'b00};
        if (!d_neg) begin
            q_new  = q4 + d_ext;
            qm_new = (d_ext != '0) ? (q4 + d_ext - RW'(1)) : (qm4 + RW'(3));
        end else begin
            q_new  = qm4 + RW'(4) + d_ext;
            qm_new = qm4 + RW'(3) + d_ext;
        end
    end

    // ------------------------------------------------------------------ datapath next state
    always_comb begin
        q_d       = q_q;
        qm_d      = qm_q;
        cnt_d     = cnt_q;
        full_d    = full_q;
        result_d  = result_q;
        overrun_d = overrun_q | (start & ~accept);
        if (accept) begin
            q_d    = '0;
            qm_d   = '1;
            cnt_d  = '0;
            full_d = full_result_sel;
        end else begin
            unique case (state_q)
                StSkip: begin
                    cnt_d = (cnt_q == CntW'(SkipLast)) ? '0 : cnt_q + CntW'(1);
                end
                StCollect: begin
                    q_d   = q_new;
                    qm_d  = qm_new;
                    cnt_d = cnt_q + CntW'(1);
                end
                StAlign: begin
                    // Short results are left-aligned: N zero digits appended.
                    result_d = full_q ? q_q : (q_q << (2 * no_of_digits));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q       <= '0;
            qm_q      <= '1;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            result_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            qm_q      <= qm_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            result_q  <= result_d;
            overrun_q <= overrun_d;
        end
    end

    assign result  = result_q;
    assign overrun = overrun_q;

    // ------------------------------------------------------------------ illegal digit check
`ifdef RADIX4_COLLECT_DIGIT_CHECK_EN
    localparam logic [radix_bits-1:0] IllegalDigit = {1'b1, {(radix_bits - 1){1'b0}}};

    logic digit_err_q, digit_err_d;

    assign illegal = (z == IllegalDigit);

    always_comb begin
        digit_err_d = digit_err_q;
        if (accept) begin
            digit_err_d = 1'b0;
        end else if ((state_q == StCollect) && illegal) begin
            digit_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_err_q <= 1'b0;
        end else begin
            digit_err_q <= digit_err_d;
        end
    end

    assign digit_err = digit_err_q;
`else
    assign illegal   = 1'b0;
    assign digit_err = 1'b0;
`endif

endmodule
